// File: rtl/ahblite_busmatrix_inputstage_dcode.sv
// ahblite_busmatrix_inputstage_dcode: D-code master input stage that holds a blocked address phase until the output stage grants it
module ahblite_busmatrix_inputstage_dcode (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL_I,
    input  logic [31:0] HADDR_I,
    input  logic [1:0]  HTRANS_I,
    input  logic        HWRITE_I,
    input  logic [2:0]  HSIZE_I,
    input  logic [2:0]  HBURST_I,
    input  logic [3:0]  HPROT_I,
    input  logic        HREADY_I,
    output logic        HREADYOUT_O,
    output logic        HRESP_O,
    output logic [31:0] HADDR_O,
    output logic [1:0]  HTRANS_O,
    output logic        HWRITE_O,
    output logic [2:0]  HSIZE_O,
    output logic [2:0]  HBURST_O,
    output logic [3:0]  HPROT_O,
    output logic        REQ_O,
    input  logic        GRANT_I,
    input  logic        HREADY_S,
    input  logic        HRESP_S
);
    typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, DPHASE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [31:0] haddr_q;
    logic [1:0]  htrans_q;
    logic        hwrite_q;
    logic [2:0]  hsize_q;
    logic [2:0]  hburst_q;
    logic [3:0]  hprot_q;
    logic        new_xfer, accept, pend, dphase, enter_pend;

    assign new_xfer   = HSEL_I & HTRANS_I[1] & HREADY_I;
    assign accept     = GRANT_I & HREADY_S;
    assign pend       = (state_q == PEND);
    assign dphase     = (state_q == DPHASE);
    assign enter_pend = (state_d == PEND) & ~pend;

    // next-state: a new transfer either goes straight to its data phase or waits in PEND for a grant
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = new_xfer ? (accept ? DPHASE : PEND) : IDLE;
            PEND:    state_d = accept ? DPHASE : PEND;
            DPHASE:  state_d = !HREADY_S ? DPHASE : new_xfer ? (accept ? DPHASE : PEND) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // capture the blocked address phase only on entry to PEND so a later input change cannot corrupt it
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr_q  <= '0;
            htrans_q <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            hburst_q <= '0;
            hprot_q  <= '0;
        end else if (enter_pend) begin
            haddr_q  <= HADDR_I;
            htrans_q <= HTRANS_I;
            hwrite_q <= HWRITE_I;
            hsize_q  <= HSIZE_I;
            hburst_q <= HBURST_I;
            hprot_q  <= HPROT_I;
        end
    end

    // reset gating keeps REQ_O and HTRANS_O quiet even though the master inputs may still be active
    always_comb begin
        HADDR_O     = pend ? haddr_q  : HADDR_I;
        HWRITE_O    = pend ? hwrite_q : HWRITE_I;
        HSIZE_O     = pend ? hsize_q  : HSIZE_I;
        HBURST_O    = pend ? hburst_q : HBURST_I;
        HPROT_O     = pend ? hprot_q  : HPROT_I;
        HTRANS_O    = pend ? htrans_q : (HRESETn & HSEL_I & HREADY_I) ? HTRANS_I : 2'b00;
        REQ_O       = HRESETn & (pend | new_xfer);
        HREADYOUT_O = dphase ? HREADY_S : ~pend;
        HRESP_O     = dphase & HRESP_S;
    end
endmodule

// File: tb/tb_ahblite_busmatrix_inputstage_dcode.sv
// tb_ahblite_busmatrix_inputstage_dcode: directed checks of the D-code input stage
module tb_ahblite_busmatrix_inputstage_dcode;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL_I = 1'b0;
    logic [31:0] HADDR_I = '0;
    logic [1:0]  HTRANS_I = '0;
    logic        HWRITE_I = 1'b0;
    logic [2:0]  HSIZE_I = '0;
    logic [2:0]  HBURST_I = '0;
    logic [3:0]  HPROT_I = '0;
    logic        HREADY_I = 1'b1;
    logic        HREADYOUT_O, HRESP_O, HWRITE_O, REQ_O;
    logic [31:0] HADDR_O;
    logic [1:0]  HTRANS_O;
    logic [2:0]  HSIZE_O, HBURST_O;
    logic [3:0]  HPROT_O;
    logic        GRANT_I = 1'b0;
    logic        HREADY_S = 1'b1;
    logic        HRESP_S = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] fwd[$];

    ahblite_busmatrix_inputstage_dcode dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL_I(HSEL_I), .HADDR_I(HADDR_I),
        .HTRANS_I(HTRANS_I), .HWRITE_I(HWRITE_I), .HSIZE_I(HSIZE_I), .HBURST_I(HBURST_I),
        .HPROT_I(HPROT_I), .HREADY_I(HREADY_I), .HREADYOUT_O(HREADYOUT_O), .HRESP_O(HRESP_O),
        .HADDR_O(HADDR_O), .HTRANS_O(HTRANS_O), .HWRITE_O(HWRITE_O), .HSIZE_O(HSIZE_O),
        .HBURST_O(HBURST_O), .HPROT_O(HPROT_O), .REQ_O(REQ_O), .GRANT_I(GRANT_I),
        .HREADY_S(HREADY_S), .HRESP_S(HRESP_S)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                         input logic rdy_i, input logic gnt, input logic rdy_s, input logic rsp_s);
        HSEL_I = sel; HADDR_I = addr; HTRANS_I = trans; HREADY_I = rdy_i;
        GRANT_I = gnt; HREADY_S = rdy_s; HRESP_S = rsp_s;
        #1;
    endtask

    logic [31:0] b_addr[7]  = '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008, 32'h300C, 32'h0};
    logic [1:0]  b_trans[7] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    logic        b_rdy[7]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        drive(1'b1, 32'h1234, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst_hreadyout", HREADYOUT_O, 1);
        chk("rst_hresp", HRESP_O, 0);
        chk("rst_req", REQ_O, 0);
        chk("rst_htrans", HTRANS_O, 0);
        drive(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc; cyc;
        HRESETn = 1'b1;
        cyc;

        drive(1'b1, 32'h1000, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("nw_haddr", HADDR_O, 32'h1000);
        chk("nw_req", REQ_O, 1);
        chk("nw_htrans", HTRANS_O, 2);
        cyc;
        drive(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("nw_dphase_wait", HREADYOUT_O, 0);
        chk("nw_idle_htrans", HTRANS_O, 0);
        chk("nw_no_req", REQ_O, 0);
        drive(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("nw_dphase_rdy", HREADYOUT_O, 1);
        cyc;
        drive(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("nw_back_idle", HREADYOUT_O, 1);

        HWRITE_I = 1'b1; HSIZE_I = 3'd2; HPROT_I = 4'h3;
        drive(1'b1, 32'h2004, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("blk_req0", REQ_O, 1);
        chk("blk_hready0", HREADYOUT_O, 1);
        cyc;
        HWRITE_I = 1'b0; HSIZE_I = 3'd0; HPROT_I = 4'h0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hDEADBEEF, 2'd0, 1'b0, i == 2, 1'b1, 1'b0);
            chk("blk_hreadyout", HREADYOUT_O, 0);
            chk("blk_haddr", HADDR_O, 32'h2004);
            chk("blk_req", REQ_O, 1);
            chk("blk_htrans", HTRANS_O, 2);
            chk("blk_hwrite", HWRITE_O, 1);
            chk("blk_hsize", HSIZE_O, 2);
            chk("blk_hprot", HPROT_O, 4'h3);
            cyc;
        end
        drive(1'b0, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("blk_dphase", HREADYOUT_O, 0);
        chk("blk_passthru", HADDR_O, 32'hDEADBEEF);
        chk("blk_dp_req", REQ_O, 0);
        drive(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc;

        HBURST_I = 3'd3;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, b_addr[i], b_trans[i], b_rdy[i], 1'b1, b_rdy[i], 1'b0);
            chk("bst_hreadyout", HREADYOUT_O, b_rdy[i]);
            chk("bst_req", REQ_O, b_trans[i][1] & b_rdy[i]);
            chk("bst_htrans", HTRANS_O, b_rdy[i] ? b_trans[i] : 2'd0);
            chk("bst_hburst", HBURST_O, 3);
            if (REQ_O && HREADY_S) fwd.push_back(HADDR_O);
            cyc;
        end
        chk("bst_count", fwd.size(), 4);
        for (int i = 0; i < 4; i++) chk("bst_order", fwd.size() > i ? fwd[i] : 32'hX, 32'h3000 + 4 * i);
        HBURST_I = 3'd0;

        drive(1'b1, 32'h4000, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc;
        drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("err1_hresp", HRESP_O, 1);
        chk("err1_hready", HREADYOUT_O, 0);
        cyc;
        drive(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("err2_hresp", HRESP_O, 1);
        chk("err2_hready", HREADYOUT_O, 1);
        cyc;
        drive(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("err_idle_hready", HREADYOUT_O, 1);
        chk("err_idle_hresp", HRESP_O, 0);

        drive(1'b1, 32'h4400, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("busy_req", REQ_O, 0);
        chk("busy_htrans", HTRANS_O, 1);
        cyc;
        drive(1'b1, 32'h4400, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("busy_still_idle", HREADYOUT_O, 1);
        chk("idle_req", REQ_O, 0);
        cyc;

        drive(1'b1, 32'h5000, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc;
        drive(1'b1, 32'h5555, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rp_pend_hready", HREADYOUT_O, 0);
        chk("rp_pend_haddr", HADDR_O, 32'h5000);
        HRESETn = 1'b0;
        #1;
        chk("rp_hready", HREADYOUT_O, 1);
        chk("rp_req", REQ_O, 0);
        chk("rp_htrans", HTRANS_O, 0);
        chk("rp_hold", dut.haddr_q, 0);
        drive(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc;
        HRESETn = 1'b1;
        cyc;
        #1;
        chk("rp_idle_hready", HREADYOUT_O, 1);
        chk("rp_idle_req", REQ_O, 0);
        chk("rp_idle_haddr", HADDR_O, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
